q_cnot_seq: RTL
===============

Name: q_cnot_seq

Overview:
- Sequential, parametrised CNOT engine operating on a full NUM_QUBITS-qubit state vector rather than two separable single-qubit inputs.
- Streams in 2^NUM_QUBITS complex fixed-point amplitudes, applies CNOT with runtime-selectable control and target qubit indices by permuting amplitudes in an internal buffer, then streams the result out.
- Sits between the state-vector memory and the other gate engines in the gate pipeline.

Parameters:
- NUM_QUBITS, 3, number of qubits in the state vector; legal range 2..8; buffer depth DEPTH = 2^NUM_QUBITS.
- IDX_W, $clog2(NUM_QUBITS), width of the qubit-index ports; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to run a gate; sampled only in IDLE.
- ctrl_idx  in  IDX_W  control qubit index, sampled with start.
- tgt_idx  in  IDX_W  target qubit index, sampled with start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last output beat is accepted.
- err  out  1  one-cycle pulse on a rejected start.
- in_valid  in  1  input amplitude valid.
- in_ready  out  1  high only in LOAD.
- in_real  in  `FIXED_WIDTH  signed real part of the input amplitude.
- in_imag  in  `FIXED_WIDTH  signed imaginary part of the input amplitude.
- out_valid  out  1  high only in DRAIN.
- out_ready  in  1  downstream accept.
- out_real  out  `FIXED_WIDTH  signed real part of the output amplitude.
- out_imag  out  `FIXED_WIDTH  signed imaginary part of the output amplitude.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; beat and pair counters clear.
  - busy, done, err, in_ready, out_valid, out_real and out_imag are all 0.
  - Buffer contents are not cleared.
  - Reset mid-operation abandons the gate with no done pulse.
- Amplitude ordering: beat k carries basis state |k>; qubit q is bit q of k (qubit 0 is the LSB).
- FSM IDLE:
  - If start=1 and ctrl_idx != tgt_idx and both indices < NUM_QUBITS: latch the indices and go to LOAD.
  - If start=1 with an illegal configuration: pulse err for one cycle and stay in IDLE.
- FSM LOAD:
  - Each in_valid&&in_ready handshake writes buf[k] and increments k.
  - After beat DEPTH-1 is accepted, go to APPLY the next cycle.
  - in_valid low stalls the state without loss.
- FSM APPLY:
  - Pair counter p runs 0..DEPTH/4-1, one swap per cycle.
  - Index i is formed by inserting a 1 at bit ctrl and a 0 at bit tgt into p.
  - Swap buf[i] and buf[i | (1<<tgt)], both real and imaginary parts.
  - Exactly DEPTH/4 cycles, then go to DRAIN.
- FSM DRAIN:
  - out_real/out_imag are driven from buf[k], registered, with out_valid.
  - Data holds stable while out_valid=1 and out_ready=0.
  - On a handshake, advance k.
  - After beat DEPTH-1 is accepted: out_valid=0, done=1 for one cycle, return to IDLE.
- Latency from start to the first out_valid: 1 + DEPTH + DEPTH/4 + 1 cycles, assuming no input stalls.
- start while busy is ignored; no err pulse.
- Amplitudes are permuted only; no arithmetic is performed, so no rounding or saturation occurs and values are bit-exact.
- A new start is accepted on the cycle after done.

Optional Feature:
- Macro Q_CNOT_SEQ_OPEN_CTRL_EN.
- When defined:
  - Adds an input port ctrl_pol (1 bit), sampled with start.
  - ctrl_pol=1 gives a normal CNOT.
  - ctrl_pol=0 gives an open-control CNOT: the bit inserted at the ctrl position during APPLY is 0 instead of 1, so the target flips when the control is |0>.
- When not defined: the port is absent and the control polarity is fixed at 1.

Test Plan:
- NUM_QUBITS=2, ctrl=1, tgt=0, input reals 1,2,3,4 and imags 10,20,30,40 -> output reals 1,2,4,3 and imags 10,20,40,30, one done pulse, err=0.
- NUM_QUBITS=2, ctrl=0, tgt=1, same input -> output reals 1,4,3,2; start-to-first-out_valid is 7 cycles with no stalls.
- ctrl=tgt=1 -> err pulse one cycle, busy stays 0, in_ready stays 0; a subsequent legal start proceeds normally.
- NUM_QUBITS=3, ctrl=2, tgt=0, reals 0..7; in_valid toggled 50% and out_ready toggled 50% -> output 0,1,2,3,5,4,7,6 with no dropped or duplicated beats and stable data during stalls.
- Reset asserted after 2 of 4 LOAD beats -> busy=0, no done; next run with 1,2,3,4 (ctrl=1, tgt=0) gives 1,2,4,3.
- With Q_CNOT_SEQ_OPEN_CTRL_EN, NUM_QUBITS=2, ctrl=1, tgt=0, ctrl_pol=0, input 1,2,3,4 -> output 2,1,3,4.

Source files
------------

// File: rtl/q_cnot_seq_if.sv
// Bus bundle for q_cnot_seq: gate request/status plus the input and output amplitude streams.
// The ctrl_pol signal exists only when Q_CNOT_SEQ_OPEN_CTRL_EN is defined.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

interface q_cnot_seq_if #(
   parameter int NUM_QUBITS = 3,
   localparam int IDX_W = $clog2(NUM_QUBITS)
);
   logic                           start;
   logic [IDX_W-1:0]               ctrl_idx;
   logic [IDX_W-1:0]               tgt_idx;
`ifdef Q_CNOT_SEQ_OPEN_CTRL_EN
   logic                           ctrl_pol;
`endif
   logic                           busy;
   logic                           done;
   logic                           err;
   logic                           in_valid;
   logic                           in_ready;
   logic signed [`FIXED_WIDTH-1:0] in_real;
   logic signed [`FIXED_WIDTH-1:0] in_imag;
   logic                           out_valid;
   logic                           out_ready;
   logic signed [`FIXED_WIDTH-1:0] out_real;
   logic signed [`FIXED_WIDTH-1:0] out_imag;

   // Upstream side: issues gate requests, feeds amplitudes, accepts results.
   modport master (
      output start, ctrl_idx, tgt_idx,
`ifdef Q_CNOT_SEQ_OPEN_CTRL_EN
      output ctrl_pol,
`endif
      output in_valid, in_real, in_imag, out_ready,
      input  busy, done, err, in_ready, out_valid, out_real, out_imag
   );

   // Engine side.
   modport slave (
      input  start, ctrl_idx, tgt_idx,
`ifdef Q_CNOT_SEQ_OPEN_CTRL_EN
      input  ctrl_pol,
`endif
      input  in_valid, in_real, in_imag, out_ready,
      output busy, done, err, in_ready, out_valid, out_real, out_imag
   );
endinterface

// File: rtl/q_cnot_seq.sv
// Sequential CNOT engine: loads a 2^NUM_QUBITS amplitude state vector, swaps the
// amplitude pairs selected by the control/target qubits, then streams the vector out.
// Optional open-control polarity (ctrl_pol port) is enabled by Q_CNOT_SEQ_OPEN_CTRL_EN.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

module q_cnot_seq #(
   parameter int NUM_QUBITS = 3
) (
   input logic         clk,
   input logic         rst_n,
   q_cnot_seq_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_QUBITS);
   localparam int DEPTH = 1 << NUM_QUBITS;
   localparam int PAIRS = DEPTH / 4;
   localparam int W     = `FIXED_WIDTH;
   localparam logic [NUM_QUBITS-1:0] LAST_BEAT = NUM_QUBITS'(DEPTH - 1);
   localparam logic [NUM_QUBITS-1:0] LAST_PAIR = NUM_QUBITS'(PAIRS - 1);
   localparam logic [NUM_QUBITS-1:0] ONE       = NUM_QUBITS'(1);

   typedef enum logic [1:0] {IDLE, LOAD, APPLY, DRAIN} state_t;

   state_t                state;
   logic [NUM_QUBITS-1:0] beat_cnt;
   logic [NUM_QUBITS-1:0] pair_cnt;
   logic [IDX_W-1:0]      ctrl_q;
   logic [IDX_W-1:0]      tgt_q;
   logic                  ctrl_bit_q;
   logic                  busy_r;
   logic                  done_r;
   logic                  err_r;
   logic                  in_ready_r;
   logic                  out_valid_r;
   logic signed [W-1:0]   out_real_r;
   logic signed [W-1:0]   out_imag_r;
   logic signed [W-1:0]   buf_re [DEPTH];
   logic signed [W-1:0]   buf_im [DEPTH];

   logic                  cfg_ok;
   logic                  ctrl_bit_in;
   logic [IDX_W-1:0]      lo_pos;
   logic [IDX_W-1:0]      hi_pos;
   logic                  lo_bit;
   logic                  hi_bit;
   logic [NUM_QUBITS-1:0] mid_idx;
   logic [NUM_QUBITS-1:0] swap_a;
   logic [NUM_QUBITS-1:0] swap_b;
   logic [NUM_QUBITS-1:0] beat_nxt;
   logic                  in_fire;

   // Open-ups bits above pos by one place and drops bit value b into the gap.
   function automatic logic [NUM_QUBITS-1:0] insert_bit(
      input logic [NUM_QUBITS-1:0] v,
      input logic [IDX_W-1:0]      pos,
      input logic                  b
   );
      logic [NUM_QUBITS:0] ext;
      logic [NUM_QUBITS:0] mask;
      logic [NUM_QUBITS:0] res;
      ext  = {1'b0, v};
      mask = (NUM_QUBITS+1)'((1 << pos) - 1);
      res  = ((ext & ~mask) << 1) | ((NUM_QUBITS+1)'(b) << pos) | (ext & mask);
      return res[NUM_QUBITS-1:0];
   endfunction

`ifdef Q_CNOT_SEQ_OPEN_CTRL_EN
   assign ctrl_bit_in = bus.ctrl_pol;
`else
   assign ctrl_bit_in = 1'b1;
`endif

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_real  = out_real_r;
   assign bus.out_imag  = out_imag_r;

   assign beat_nxt = beat_cnt + ONE;
   assign in_fire  = bus.in_valid && in_ready_r;

   // Request check: indices must differ and both name an existing qubit.
   always_comb begin
      cfg_ok = (bus.ctrl_idx != bus.tgt_idx) &&
               (int'(bus.ctrl_idx) < NUM_QUBITS) &&
               (int'(bus.tgt_idx) < NUM_QUBITS);
   end

   // Pair address: insert the lower-position bit first so the upper position stays valid.
   always_comb begin
      if (ctrl_q < tgt_q) begin
         lo_pos = ctrl_q;
         lo_bit = ctrl_bit_q;
         hi_pos = tgt_q;
         hi_bit = 1'b0;
      end else begin
         lo_pos = tgt_q;
         lo_bit = 1'b0;
         hi_pos = ctrl_q;
         hi_bit = ctrl_bit_q;
      end
      mid_idx = insert_bit(pair_cnt, lo_pos, lo_bit);
      swap_a  = insert_bit(mid_idx, hi_pos, hi_bit);
      swap_b  = swap_a | (ONE << tgt_q);
   end

   // Sequencer with registered status and output stream; DRAIN spends one cycle prefetching beat 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         beat_cnt    <= '0;
         pair_cnt    <= '0;
         ctrl_q      <= '0;
         tgt_q       <= '0;
         ctrl_bit_q  <= 1'b1;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_real_r  <= '0;
         out_imag_r  <= '0;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (cfg_ok) begin
                     ctrl_q     <= bus.ctrl_idx;
                     tgt_q      <= bus.tgt_idx;
                     ctrl_bit_q <= ctrl_bit_in;
                     beat_cnt   <= '0;
                     busy_r     <= 1'b1;
                     in_ready_r <= 1'b1;
                     state      <= LOAD;
                  end else begin
                     err_r <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (in_fire) begin
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt   <= '0;
                     pair_cnt   <= '0;
                     in_ready_r <= 1'b0;
                     state      <= APPLY;
                  end else begin
                     beat_cnt <= beat_nxt;
                  end
               end
            end
            APPLY: begin
               if (pair_cnt == LAST_PAIR) begin
                  pair_cnt <= '0;
                  state    <= DRAIN;
               end else begin
                  pair_cnt <= pair_cnt + ONE;
               end
            end
            DRAIN: begin
               if (!out_valid_r) begin
                  out_real_r  <= buf_re[beat_cnt];
                  out_imag_r  <= buf_im[beat_cnt];
                  out_valid_r <= 1'b1;
               end else if (bus.out_ready) begin
                  if (beat_cnt == LAST_BEAT) begin
                     out_valid_r <= 1'b0;
                     out_real_r  <= '0;
                     out_imag_r  <= '0;
                     beat_cnt    <= '0;
                     busy_r      <= 1'b0;
                     done_r      <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     beat_cnt   <= beat_nxt;
                     out_real_r <= buf_re[beat_nxt];
                     out_imag_r <= buf_im[beat_nxt];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Amplitude buffer: filled during LOAD, pairs exchanged during APPLY; contents survive reset.
   always_ff @(posedge clk) begin
      if (state == LOAD && in_fire) begin
         buf_re[beat_cnt] <= bus.in_real;
         buf_im[beat_cnt] <= bus.in_imag;
      end else if (state == APPLY) begin
         buf_re[swap_a] <= buf_re[swap_b];
         buf_re[swap_b] <= buf_re[swap_a];
         buf_im[swap_a] <= buf_im[swap_b];
         buf_im[swap_b] <= buf_im[swap_a];
      end
   end
endmodule
